// File: rtl/i2c_line_cond.sv
// SCL/SDA input conditioning: synchronise, spike-filter, then derive edge/START/STOP/busy/timeout.
// Latency pin->level SYNC_STAGES+max(filt_len_i,1) cycles, events one cycle later; no backpressure.

module i2c_line_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              i2c_core_clk,
  input  logic              i2c_reset_n,
  input  logic              line_i,
  input  logic [FILT_W-1:0] lim_i,
  output logic              line_f_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt;
  logic                   s_line;

  assign s_line = sync_q[SYNC_STAGES-1];

  // >= rather than == so a shortened filt_len_i takes effect on the next differing cycle
  always_ff @(posedge i2c_core_clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      sync_q   <= '1;
      cnt      <= '0;
      line_f_o <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      if (s_line == line_f_o) begin
        cnt <= '0;
      end else if (cnt >= lim_i) begin
        line_f_o <= s_line;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module i2c_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int TO_W        = 16
) (
  input  logic              i2c_core_clk,
  input  logic              i2c_reset_n,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              to_en_i,
  output logic              scl_f_o,
  output logic              sda_f_o,
  output logic              scl_rise_o,
  output logic              scl_fall_o,
  output logic              start_o,
  output logic              stop_o,
  output logic              bus_busy_o,
  output logic              scl_to_o
);

  localparam logic [TO_W-1:0] TO_MAX  = '1;
  localparam logic [TO_W-1:0] TO_NEAR = TO_MAX - 1'b1;

  logic [FILT_W-1:0] lim;
  logic              scl_p;
  logic              sda_p;
  logic              start_c;
  logic              stop_c;
  logic [TO_W-1:0]   tcnt;

  // filt_len_i of 0 is treated as 1: terminal count L-1 floors at 0
  always_comb begin
    lim = '0;
    if (filt_len_i != '0) lim = filt_len_i - 1'b1;
  end

  i2c_line_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_scl_filt (
    .i2c_core_clk (i2c_core_clk),
    .i2c_reset_n  (i2c_reset_n),
    .line_i       (scl_i),
    .lim_i        (lim),
    .line_f_o     (scl_f_o)
  );

  i2c_line_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_sda_filt (
    .i2c_core_clk (i2c_core_clk),
    .i2c_reset_n  (i2c_reset_n),
    .line_i       (sda_i),
    .lim_i        (lim),
    .line_f_o     (sda_f_o)
  );

  // SCL stable high across both samples excludes simultaneous SCL/SDA changes
  assign start_c = scl_p & scl_f_o & sda_p & ~sda_f_o;
  assign stop_c  = scl_p & scl_f_o & ~sda_p & sda_f_o;

  always_ff @(posedge i2c_core_clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      scl_p      <= 1'b1;
      sda_p      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      bus_busy_o <= 1'b0;
    end else begin
      scl_p      <= scl_f_o;
      sda_p      <= sda_f_o;
      scl_rise_o <= scl_f_o & ~scl_p;
      scl_fall_o <= ~scl_f_o & scl_p;
      start_o    <= start_c;
      stop_o     <= stop_c;
      bus_busy_o <= start_c | (bus_busy_o & ~stop_c);
    end
  end

  // Pulse only on the 14->15 style transition, so saturation never re-fires
  always_ff @(posedge i2c_core_clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      tcnt     <= '0;
      scl_to_o <= 1'b0;
    end else if (!to_en_i || scl_f_o) begin
      tcnt     <= '0;
      scl_to_o <= 1'b0;
    end else begin
      if (tcnt != TO_MAX) tcnt <= tcnt + 1'b1;
      scl_to_o <= (tcnt == TO_NEAR);
    end
  end

endmodule

// File: tb/tb_i2c_line_cond.sv
// Bench for i2c_line_cond: directed protocol scenarios plus randomized line activity,
// checked against a run-length reference model of the filter and event rules.

module tb_i2c_line_cond;

  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int TW   = 4;
  localparam int TO_RUN = (1 << TW) - 1;

  logic          i2c_core_clk = 1'b0;
  logic          i2c_reset_n  = 1'b1;
  logic          scl_i = 1'b1;
  logic          sda_i = 1'b1;
  logic [FW-1:0] filt_len_i = 4'd3;
  logic          to_en_i = 1'b0;
  logic          scl_f_o, sda_f_o, scl_rise_o, scl_fall_o;
  logic          start_o, stop_o, bus_busy_o, scl_to_o;

  i2c_line_cond #(.SYNC_STAGES(SYNC), .FILT_W(FW), .TO_W(TW)) dut (
    .i2c_core_clk (i2c_core_clk),
    .i2c_reset_n  (i2c_reset_n),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .filt_len_i   (filt_len_i),
    .to_en_i      (to_en_i),
    .scl_f_o      (scl_f_o),
    .sda_f_o      (sda_f_o),
    .scl_rise_o   (scl_rise_o),
    .scl_fall_o   (scl_fall_o),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .bus_busy_o   (bus_busy_o),
    .scl_to_o     (scl_to_o)
  );

  always #5 i2c_core_clk = ~i2c_core_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pin delay lines, recent synchronised samples, filtered levels
  int L;
  bit q_scl[$], q_sda[$], w_scl[$], w_sda[$];
  bit m_sf, m_sp, m_df, m_dp, m_busy;
  bit e_rise, e_fall, e_start, e_stop, e_to;
  int run;
  int n_start, n_stop, n_fall, n_to, n_sda_low, to_cyc, cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A level passes once the last L synchronised samples all disagree with the filtered level
  function automatic bit all_differ(input bit w[$], input bit f, input int len);
    if (w.size() < len) return 1'b0;
    for (int i = 0; i < len; i++) if (w[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    L = (filt_len_i == 0) ? 1 : int'(filt_len_i);
    q_scl.delete(); q_sda.delete(); w_scl.delete(); w_sda.delete();
    for (int i = 0; i < SYNC; i++) begin q_scl.push_front(1'b1); q_sda.push_front(1'b1); end
    m_sf = 1; m_sp = 1; m_df = 1; m_dp = 1; m_busy = 0;
    e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0; e_to = 0;
    run = 0;
  endtask

  task automatic step(input bit scl, input bit sda, input bit ten);
    bit s_scl, s_sda, nsf, ndf;
    scl_i = scl; sda_i = sda; to_en_i = ten;
    @(posedge i2c_core_clk);
    cyc++;
    s_scl = q_scl[$]; void'(q_scl.pop_back()); q_scl.push_front(scl);
    s_sda = q_sda[$]; void'(q_sda.pop_back()); q_sda.push_front(sda);
    w_scl.push_front(s_scl); if (w_scl.size() > 16) void'(w_scl.pop_back());
    w_sda.push_front(s_sda); if (w_sda.size() > 16) void'(w_sda.pop_back());
    e_rise  = m_sf & !m_sp;
    e_fall  = !m_sf & m_sp;
    e_start = m_sp & m_sf & m_dp & !m_df;
    e_stop  = m_sp & m_sf & !m_dp & m_df;
    m_busy  = e_start | (m_busy & !e_stop);
    run     = (ten && !m_sf) ? run + 1 : 0;
    e_to    = (run == TO_RUN);
    nsf = all_differ(w_scl, m_sf, L) ? !m_sf : m_sf;
    ndf = all_differ(w_sda, m_df, L) ? !m_df : m_df;
    m_sp = m_sf; m_sf = nsf;
    m_dp = m_df; m_df = ndf;
    #1;
    chk("scl_f", scl_f_o, m_sf);
    chk("sda_f", sda_f_o, m_df);
    chk("scl_rise", scl_rise_o, e_rise);
    chk("scl_fall", scl_fall_o, e_fall);
    chk("start", start_o, e_start);
    chk("stop", stop_o, e_stop);
    chk("busy", bus_busy_o, m_busy);
    chk("scl_to", scl_to_o, e_to);
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (scl_fall_o) n_fall++;
    if (scl_to_o) begin n_to++; to_cyc = cyc; end
    if (!sda_f_o) n_sda_low++;
  endtask

  task automatic do_reset(input bit scl, input bit sda, input logic [FW-1:0] flen);
    scl_i = scl; sda_i = sda; filt_len_i = flen;
    @(negedge i2c_core_clk);
    i2c_reset_n = 1'b0;
    #1;
    chk("rst_scl_f", scl_f_o, 1);
    chk("rst_sda_f", sda_f_o, 1);
    chk("rst_pulses", {scl_rise_o, scl_fall_o, start_o, stop_o, scl_to_o}, 0);
    chk("rst_busy", bus_busy_o, 0);
    repeat (2) @(posedge i2c_core_clk);
    @(negedge i2c_core_clk);
    i2c_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic clr_counts();
    n_start = 0; n_stop = 0; n_fall = 0; n_to = 0; n_sda_low = 0; cyc = 0; to_cyc = -1;
  endtask

  initial begin
    bit cs, cd, ten;
    int ls, ld;
    logic [FW-1:0] lens [5] = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd5};

    // Reset with both lines low, then the filtered lines fall 5 cycles after release
    do_reset(1'b0, 1'b0, 4'd3);
    clr_counts();
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0);
      if (i == 4) chk("rel_scl_hi_c4", scl_f_o, 1);
      if (i == 5) chk("rel_scl_lo_c5", scl_f_o, 0);
      if (i == 6) chk("rel_fall_c6", scl_fall_o, 1);
    end
    step(0, 0, 0);
    chk("rel_fall_once", n_fall, 1);
    chk("rel_no_start", n_start, 0);
    repeat (8) step(1, 1, 0);

    // 2-cycle SDA spike suppressed, 3-cycle one passes
    clr_counts();
    repeat (2) step(1, 0, 0);
    repeat (8) step(1, 1, 0);
    chk("spike2_start", n_start, 0);
    chk("spike2_sda_low", n_sda_low, 0);
    clr_counts();
    repeat (3) step(1, 0, 0);
    repeat (10) step(1, 1, 0);
    chk("spike3_start", n_start, 1);
    chk("spike3_sda_low", n_sda_low, 3);

    // START held, then STOP
    clr_counts();
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (i == 5) chk("start_sda_f_c5", sda_f_o, 0);
      if (i == 6) chk("start_c6", {start_o, bus_busy_o}, 2'b11);
    end
    repeat (10) step(1, 1, 0);
    chk("stop_once", n_stop, 1);
    chk("stop_busy_clr", bus_busy_o, 0);

    // Repeated START keeps the bus busy
    clr_counts();
    repeat (10) step(1, 0, 0);
    repeat (8) step(0, 0, 0);
    repeat (8) step(0, 1, 0);
    repeat (8) step(1, 1, 0);
    repeat (8) step(1, 0, 0);
    chk("rstart_count", n_start, 2);
    chk("rstart_stop", n_stop, 0);
    chk("rstart_busy", bus_busy_o, 1);
    repeat (8) step(1, 1, 0);
    chk("rstart_end_busy", bus_busy_o, 0);

    // Both lines fall together: SCL edge only
    clr_counts();
    repeat (10) step(0, 0, 0);
    repeat (10) step(1, 1, 0);
    chk("simul_fall", n_fall, 1);
    chk("simul_events", n_start + n_stop, 0);

    // Timeout fires once, 15 cycles after the filtered fall (cycle 5)
    clr_counts();
    repeat (40) step(0, 1, 1);
    chk("to_once", n_to, 1);
    chk("to_cycle", to_cyc, 5 + TO_RUN);
    repeat (10) step(1, 1, 1);
    clr_counts();
    repeat (40) step(0, 1, 0);
    chk("to_disabled", n_to, 0);
    repeat (10) step(1, 1, 0);

    // Reset mid-count: count restarts from the post-reset fall
    repeat (15) step(0, 1, 1);
    do_reset(1'b0, 1'b1, 4'd3);
    clr_counts();
    repeat (18) step(0, 1, 1);
    chk("to_after_rst", n_to, 0);
    repeat (10) step(0, 1, 1);
    chk("to_after_rst_late", n_to, 1);

    // Randomized line activity across several filter lengths
    foreach (lens[k]) begin
      do_reset(1'b1, 1'b1, lens[k]);
      cs = 1; cd = 1; ls = 0; ld = 0; ten = 1;
      for (int i = 0; i < 600; i++) begin
        if (ls == 0) begin
          cs = 1'($urandom_range(0, 1));
          ls = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 8));
        end
        if (ld == 0) begin
          cd = 1'($urandom_range(0, 1));
          ld = int'($urandom_range(1, 8));
        end
        if ($urandom_range(0, 63) == 0) ten = !ten;
        step(cs, cd, ten);
        ls--; ld--;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
